// File: rtl/risc_v_mike_fetch_unit.sv
// risc_v_mike instruction fetch stage.
// Owns the PC, reads a combinational instruction memory, and registers the word into
// an IF/ID slot with a valid/ready handshake toward decode. Execute can redirect the PC.
// Optional feature macro: RISC_V_MIKE_FETCH_FAULT_EN
//   defined   -> misaligned or out-of-window PCs raise a sticky fault and halt fetch
//   undefined -> redirects are word-aligned and folded into the text window; the
//                sequential PC wraps from the window end back to RESET_PC
// TEXT_DEPTH is expected to be a power of two so the window fold is a cheap mask.
module risc_v_mike_fetch_unit #(
  parameter logic [31:0] RESET_PC   = 32'h0040_0000,
  parameter int unsigned TEXT_DEPTH = 1024
) (
  input  logic        clk_i,
  input  logic        rst_ni,
  output logic [31:0] pc_addr_o,
  input  logic [31:0] imem_rd_data_i,
  input  logic        redirect_valid_i,
  input  logic [31:0] redirect_addr_i,
  input  logic        if_id_ready_i,
  output logic        if_id_valid_o,
  output logic [31:0] if_id_instr_o,
  output logic [31:0] if_id_pc_o,
  output logic [31:0] if_id_pc_plus4_o,
  output logic [31:0] fetch_count_o,
  output logic        fetch_fault_o
);

  localparam logic [31:0] WinBytes = 32'(TEXT_DEPTH) << 2;
  localparam logic [31:0] NopInstr = 32'h0000_0013;

  typedef enum logic [1:0] {StBoot, StRun, StHalt} state_e;

  state_e      state_q, state_d;
  logic [31:0] pc_q, pc_d;
  logic        valid_q, valid_d;
  logic [31:0] instr_q, instr_d;
  logic [31:0] id_pc_q, id_pc_d;
  logic [31:0] id_pc4_q, id_pc4_d;
  logic [31:0] count_q, count_d;
  logic        fault_q, fault_d;

  logic [31:0] pc_seq;
  logic [31:0] seq_target;
  logic [31:0] redir_target;
  logic        seq_fault;
  logic        redir_fault;
  logic        transfer;
  logic        load;

  // Offset from RESET_PC wraps mod 2^32, so one compare covers both window edges.
  function automatic logic in_window(logic [31:0] addr);
    logic [31:0] off;
    off = addr - RESET_PC;
    return off < WinBytes;
  endfunction

  // Candidate next PCs for the sequential and redirect paths, with their fault flags.
  always_comb begin
    pc_seq = pc_q + 32'd4;
`ifdef RISC_V_MIKE_FETCH_FAULT_EN
    seq_target   = pc_seq;
    redir_target = redirect_addr_i;
    seq_fault    = !in_window(pc_seq);
    redir_fault  = (redirect_addr_i[1:0] != 2'b00) || !in_window(redirect_addr_i);
`else
    seq_target   = in_window(pc_seq) ? pc_seq : RESET_PC;
    // Fold the offset into the window, then drop the byte bits (RESET_PC is word aligned).
    redir_target = RESET_PC + (((redirect_addr_i - RESET_PC) % WinBytes) & ~32'h3);
    seq_fault    = 1'b0;
    redir_fault  = 1'b0;
`endif
  end

  // Next-state for the FSM, PC, IF/ID slot and counters.
  always_comb begin
    state_d  = state_q;
    pc_d     = pc_q;
    valid_d  = valid_q;
    instr_d  = instr_q;
    id_pc_d  = id_pc_q;
    id_pc4_d = id_pc4_q;
    count_d  = count_q;
    fault_d  = fault_q;

    transfer = valid_q && if_id_ready_i;
    load     = !valid_q || if_id_ready_i;

    unique case (state_q)
      StBoot: begin
        state_d = StRun;
      end
      StRun: begin
        if (redirect_valid_i) begin
          if (redir_fault) begin
            state_d = StHalt;
            fault_d = 1'b1;
            valid_d = 1'b0;
          end else begin
            // Flush wins over stall; the word leaving to decode this edge still counts.
            pc_d    = redir_target;
            valid_d = 1'b0;
            count_d = count_q + 32'(transfer);
          end
        end else if (load) begin
          if (seq_fault) begin
            state_d = StHalt;
            fault_d = 1'b1;
            valid_d = 1'b0;
          end else begin
            instr_d  = imem_rd_data_i;
            id_pc_d  = pc_q;
            id_pc4_d = pc_seq;
            valid_d  = 1'b1;
            pc_d     = seq_target;
            count_d  = count_q + 32'(transfer);
          end
        end
      end
      StHalt: begin
        valid_d = 1'b0;
      end
      default: begin
        state_d = StBoot;
      end
    endcase
  end

  // All fetch state; asynchronous reset discards any in-flight instruction.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q  <= StBoot;
      pc_q     <= RESET_PC;
      valid_q  <= 1'b0;
      instr_q  <= NopInstr;
      id_pc_q  <= RESET_PC;
      id_pc4_q <= RESET_PC + 32'd4;
      count_q  <= 32'd0;
      fault_q  <= 1'b0;
    end else begin
      state_q  <= state_d;
      pc_q     <= pc_d;
      valid_q  <= valid_d;
      instr_q  <= instr_d;
      id_pc_q  <= id_pc_d;
      id_pc4_q <= id_pc4_d;
      count_q  <= count_d;
      fault_q  <= fault_d;
    end
  end

  assign pc_addr_o        = pc_q;
  assign if_id_valid_o    = valid_q;
  assign if_id_instr_o    = instr_q;
  assign if_id_pc_o       = id_pc_q;
  assign if_id_pc_plus4_o = id_pc4_q;
  assign fetch_count_o    = count_q;
  assign fetch_fault_o    = fault_q;

endmodule

// File: tb/tb_risc_v_mike_fetch_unit.sv
// Self-checking bench for risc_v_mike_fetch_unit: directed vector table, hand-written
// corner sequences, and randomized traffic against a word-index reference model.
module tb_risc_v_mike_fetch_unit;

  localparam logic [31:0] RP    = 32'h0040_0000;
  localparam int unsigned DEPTH = 1024;
  localparam logic [31:0] NOP   = 32'h0000_0013;

  logic        clk = 1'b0;
  logic        rst_n = 1'b1;
  logic [31:0] pc_addr;
  logic [31:0] imem_rd_data;
  logic        rv = 1'b0;
  logic [31:0] ra = 32'd0;
  logic        rdy = 1'b0;
  logic        valid;
  logic [31:0] instr, id_pc, id_pc4, count;
  logic        fault;

  int n_vec = 0;
  int n_err = 0;

  always #5 clk = ~clk;

  risc_v_mike_fetch_unit #(
    .RESET_PC  (RP),
    .TEXT_DEPTH(DEPTH)
  ) dut (
    .clk_i           (clk),
    .rst_ni          (rst_n),
    .pc_addr_o       (pc_addr),
    .imem_rd_data_i  (imem_rd_data),
    .redirect_valid_i(rv),
    .redirect_addr_i (ra),
    .if_id_ready_i   (rdy),
    .if_id_valid_o   (valid),
    .if_id_instr_o   (instr),
    .if_id_pc_o      (id_pc),
    .if_id_pc_plus4_o(id_pc4),
    .fetch_count_o   (count),
    .fetch_fault_o   (fault)
  );

  // Instruction memory contents by word index within the text window.
  function automatic logic [31:0] mem_word(logic [31:0] idx);
    case (idx)
      32'd0:   return 32'h0fc1_0417;
      32'd1:   return 32'h0010_0313;
      32'd8:   return 32'h0012_8293;
      default: return 32'hC000_0000 | (idx * 32'h0001_0003);
    endcase
  endfunction

  always_comb imem_rd_data = mem_word((pc_addr - RP) >> 2);

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %08h expected %08h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic step(input logic r_v, input logic [31:0] r_a, input logic r_dy);
    rv  = r_v;
    ra  = r_a;
    rdy = r_dy;
    @(posedge clk);
    #1;
  endtask

  // Reference model: PC held as a word index in the window.
  logic        m_boot, m_halt, m_valid, m_fault;
  logic [31:0] m_idx, m_instr, m_pc, m_count;

  task automatic model_reset();
    m_boot = 1'b1; m_halt = 1'b0; m_valid = 1'b0; m_fault = 1'b0;
    m_idx = 0; m_instr = NOP; m_pc = RP; m_count = 0;
  endtask

  task automatic model_step(input logic r_v, input logic [31:0] r_a, input logic r_dy);
    logic        xfer;
    logic [31:0] woff;
    logic        bad;
    if (m_boot) begin
      m_boot = 1'b0;
    end else if (!m_halt) begin
      xfer = m_valid && r_dy;
      if (r_v) begin
        woff = (r_a - RP) >> 2;
`ifdef RISC_V_MIKE_FETCH_FAULT_EN
        bad = (r_a[1:0] != 2'b00) || (woff >= DEPTH);
`else
        bad = 1'b0;
`endif
        if (bad) begin
          m_halt = 1'b1; m_fault = 1'b1; m_valid = 1'b0;
        end else begin
          m_idx = woff % DEPTH; m_valid = 1'b0; m_count = m_count + 32'(xfer);
        end
      end else if (!m_valid || r_dy) begin
`ifdef RISC_V_MIKE_FETCH_FAULT_EN
        bad = (m_idx == DEPTH - 1);
`else
        bad = 1'b0;
`endif
        if (bad) begin
          m_halt = 1'b1; m_fault = 1'b1; m_valid = 1'b0;
        end else begin
          m_instr = mem_word(m_idx);
          m_pc    = RP + (m_idx << 2);
          m_valid = 1'b1;
          m_idx   = (m_idx + 1) % DEPTH;
          m_count = m_count + 32'(xfer);
        end
      end
    end
  endtask

  task automatic model_compare(input string tag);
    chk({tag, " valid"}, 32'(valid), 32'(m_valid));
    chk({tag, " pc_addr"}, pc_addr, RP + (m_idx << 2));
    chk({tag, " count"}, count, m_count);
    chk({tag, " fault"}, 32'(fault), 32'(m_fault));
    if (m_valid) begin
      chk({tag, " instr"}, instr, m_instr);
      chk({tag, " if_id_pc"}, id_pc, m_pc);
      chk({tag, " pc_plus4"}, id_pc4, m_pc + 32'd4);
    end
  endtask

  // Asserts reset between edges, checks values before any edge, holds across one edge.
  task automatic do_reset();
    rst_n = 1'b0;
    #1;
    chk("rst pc_addr", pc_addr, RP);
    chk("rst valid", 32'(valid), 32'd0);
    chk("rst instr", instr, NOP);
    chk("rst if_id_pc", id_pc, RP);
    chk("rst pc_plus4", id_pc4, RP + 32'd4);
    chk("rst count", count, 32'd0);
    chk("rst fault", 32'(fault), 32'd0);
    rv = 1'b0; ra = 32'd0; rdy = 1'b1;
    @(posedge clk);
    #1;
    chk("rst hold pc_addr", pc_addr, RP);
    chk("rst hold valid", 32'(valid), 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    model_reset();
  endtask

  typedef struct {
    logic        rv;
    logic [31:0] ra;
    logic        rdy;
    logic        e_valid;
    logic [31:0] e_instr;
    logic [31:0] e_pc;
    logic [31:0] e_addr;
    logic [31:0] e_cnt;
  } vec_t;

  vec_t vecs[$];

  task automatic add(input logic r_v, input logic [31:0] r_a, input logic r_dy,
                     input logic ev, input logic [31:0] ei, input logic [31:0] ep,
                     input logic [31:0] ea, input logic [31:0] ec);
    vec_t v;
    v.rv = r_v; v.ra = r_a; v.rdy = r_dy; v.e_valid = ev;
    v.e_instr = ei; v.e_pc = ep; v.e_addr = ea; v.e_cnt = ec;
    vecs.push_back(v);
  endtask

  initial begin
    // Boot, stall, redirect-during-stall, redirect-with-transfer.
    add(0, 0, 1, 0, NOP,          RP,           RP,           0);
    add(0, 0, 1, 1, mem_word(0),  RP,           RP + 32'h04,  0);
    add(0, 0, 1, 1, mem_word(1),  RP + 32'h04,  RP + 32'h08,  1);
    add(0, 0, 0, 1, mem_word(1),  RP + 32'h04,  RP + 32'h08,  1);
    add(0, 0, 0, 1, mem_word(1),  RP + 32'h04,  RP + 32'h08,  1);
    add(0, 0, 0, 1, mem_word(1),  RP + 32'h04,  RP + 32'h08,  1);
    add(0, 0, 1, 1, mem_word(2),  RP + 32'h08,  RP + 32'h0C,  2);
    add(1, RP + 32'h20, 0, 0, 0,  0,            RP + 32'h20,  2);
    add(0, 0, 0, 1, mem_word(8),  RP + 32'h20,  RP + 32'h24,  2);
    add(0, 0, 1, 1, mem_word(9),  RP + 32'h24,  RP + 32'h28,  3);
    add(1, RP + 32'h40, 1, 0, 0,  0,            RP + 32'h40,  4);
    add(0, 0, 0, 1, mem_word(16), RP + 32'h40,  RP + 32'h44,  4);
    add(0, 0, 1, 1, mem_word(17), RP + 32'h44,  RP + 32'h48,  5);

    #2;
    do_reset();
    foreach (vecs[i]) begin
      step(vecs[i].rv, vecs[i].ra, vecs[i].rdy);
      chk($sformatf("vec%0d valid", i), 32'(valid), 32'(vecs[i].e_valid));
      chk($sformatf("vec%0d pc_addr", i), pc_addr, vecs[i].e_addr);
      chk($sformatf("vec%0d count", i), count, vecs[i].e_cnt);
      chk($sformatf("vec%0d fault", i), 32'(fault), 32'd0);
      if (vecs[i].e_valid) begin
        chk($sformatf("vec%0d instr", i), instr, vecs[i].e_instr);
        chk($sformatf("vec%0d if_id_pc", i), id_pc, vecs[i].e_pc);
        chk($sformatf("vec%0d pc_plus4", i), id_pc4, vecs[i].e_pc + 32'd4);
      end
    end

    // Window end: redirect near the top and run off the end.
    do_reset();
    step(0, 0, 1);
    chk("we boot valid", 32'(valid), 32'd0);
    step(0, 0, 1);
    chk("we w0 instr", instr, mem_word(0));
    step(1, RP + 32'hFF8, 1);
    chk("we redir addr", pc_addr, RP + 32'hFF8);
    chk("we redir count", count, 32'd1);
    step(0, 0, 1);
    chk("we w1022 instr", instr, mem_word(1022));
    chk("we w1022 addr", pc_addr, RP + 32'hFFC);
    step(0, 0, 1);
`ifdef RISC_V_MIKE_FETCH_FAULT_EN
    chk("we fault", 32'(fault), 32'd1);
    chk("we fault valid", 32'(valid), 32'd0);
    chk("we fault addr", pc_addr, RP + 32'hFFC);
    chk("we fault count", count, 32'd1);
    step(1, RP, 1);
    step(0, 0, 1);
    chk("we halt valid", 32'(valid), 32'd0);
    chk("we halt fault", 32'(fault), 32'd1);
    chk("we halt addr", pc_addr, RP + 32'hFFC);
    chk("we halt count", count, 32'd1);
`else
    chk("we w1023 instr", instr, mem_word(1023));
    chk("we w1023 pc", id_pc, RP + 32'hFFC);
    chk("we wrap addr", pc_addr, RP);
    chk("we count", count, 32'd2);
    step(0, 0, 1);
    chk("we wrap instr", instr, mem_word(0));
    chk("we wrap pc", id_pc, RP);
    chk("we wrap pc_plus4", id_pc4, RP + 32'd4);
    chk("we fault", 32'(fault), 32'd0);
`endif

    // Misaligned redirect, plus out-of-window folding when faults are disabled.
    do_reset();
    step(0, 0, 1);
    step(0, 0, 1);
    step(1, RP + 32'h6, 1);
`ifdef RISC_V_MIKE_FETCH_FAULT_EN
    chk("mis fault", 32'(fault), 32'd1);
    chk("mis valid", 32'(valid), 32'd0);
    chk("mis addr", pc_addr, RP + 32'h4);
    chk("mis count", count, 32'd0);
`else
    chk("mis addr", pc_addr, RP + 32'h4);
    chk("mis valid", 32'(valid), 32'd0);
    chk("mis count", count, 32'd1);
    step(0, 0, 0);
    chk("mis instr", instr, mem_word(1));
    chk("mis pc", id_pc, RP + 32'h4);
    step(1, 32'h003F_FFF0, 1);
    chk("below addr", pc_addr, RP + 32'hFF0);
    step(1, 32'h0040_1010, 0);
    chk("above addr", pc_addr, RP + 32'h010);
    chk("fold fault", 32'(fault), 32'd0);
`endif

    // Randomized traffic against the reference model; ends in a mid-stream reset.
    do_reset();
    for (int c = 0; c < 400; c++) begin
      logic        r_v;
      logic [31:0] r_a;
      logic        r_dy;
      r_v  = ($urandom_range(0, 7) == 0);
      r_dy = ($urandom_range(0, 3) != 0);
`ifdef RISC_V_MIKE_FETCH_FAULT_EN
      r_a = RP + (32'($urandom_range(0, DEPTH / 2)) << 2);
`else
      r_a = $urandom;
`endif
      rv = r_v; ra = r_a; rdy = r_dy;
      @(posedge clk);
      model_step(r_v, r_a, r_dy);
      #1;
      model_compare($sformatf("rnd%0d", c));
    end
    #2;
    do_reset();
    step(0, 0, 1);
    step(0, 0, 1);
    chk("reboot valid", 32'(valid), 32'd1);
    chk("reboot instr", instr, mem_word(0));
    chk("reboot count", count, 32'd0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
